// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: owner encoding and default bus widths.
// Optional feature macro: MEM_ARB_RR_EN (round-robin contention policy).
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LSU  = 2'd2
   } owner_e;

   // Only reads need a return path; a store leaves no owner behind.
   function automatic owner_e next_owner(input logic if_g,
                                         input logic lsu_g,
                                         input logic lsu_we);
      if (if_g)
         return OWN_IF;
      else if (lsu_g && !lsu_we)
         return OWN_LSU;
      else
         return OWN_NONE;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and LSU.
// MEM_ARB_RR_EN selects round-robin; default is LSU priority with starvation guard.
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic             if_req,
   input  logic             lsu_req,
`ifdef MEM_ARB_RR_EN
   input  logic             rr_if,
`else
   input  logic [CNT_W-1:0] starve_cnt,
`endif
   output logic             if_win,
   output logic             lsu_win
);

   logic prefer_if;

`ifdef MEM_ARB_RR_EN
   assign prefer_if = rr_if;
`else
   assign prefer_if = (starve_cnt >= CNT_W'(STARVE_MAX));
`endif

   assign if_win  = if_req & (~lsu_req | prefer_if);
   assign lsu_win = lsu_req & ~if_win;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch and LSU; routes 1-cycle read data back.
// Define MEM_ARB_RR_EN for round-robin contention instead of LSU priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wmask,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_gnt,
   output logic              lsu_rvalid,
   output logic [DATA_W-1:0] lsu_rdata,
   input  logic [DATA_W-1:0] ReadData,
   output logic              ReadEnable,
   output logic [ADDR_W-1:0] ReadAddr,
   output logic              WriteEnable,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [DATA_W-1:0] WriteMask,
   output logic [DATA_W-1:0] WriteData
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   owner_e owner;
   logic   if_act;
   logic   lsu_act;
   logic   lsu_ld;

   // Requests are masked during reset so every output reads 0.
   assign if_act  = if_req & ~rst;
   assign lsu_act = lsu_req & ~rst;
   assign lsu_ld  = lsu_gnt & ~lsu_we;

`ifdef MEM_ARB_RR_EN
   logic rr_if;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_pick (
      .if_req  (if_act),
      .lsu_req (lsu_act),
      .rr_if   (rr_if),
      .if_win  (if_gnt),
      .lsu_win (lsu_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_if <= 1'b1;
      else if (if_act && lsu_act)
         rr_if <= lsu_gnt;
   end
`else
   logic [CNT_W-1:0] starve_cnt;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_pick (
      .if_req     (if_act),
      .lsu_req    (lsu_act),
      .starve_cnt (starve_cnt),
      .if_win     (if_gnt),
      .lsu_win    (lsu_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else if (!if_req || if_gnt)
         starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_MAX))
         starve_cnt <= starve_cnt + CNT_W'(1);
   end
`endif

   always_comb begin
      ReadEnable  = 1'b0;
      ReadAddr    = '0;
      WriteEnable = 1'b0;
      WriteAddr   = '0;
      WriteMask   = '0;
      WriteData   = '0;
      if (if_gnt) begin
         ReadEnable = 1'b1;
         ReadAddr   = if_addr;
      end else if (lsu_ld) begin
         ReadEnable = 1'b1;
         ReadAddr   = lsu_addr;
      end else if (lsu_gnt) begin
         WriteEnable = 1'b1;
         WriteAddr   = lsu_addr;
         WriteMask   = lsu_wmask;
         WriteData   = lsu_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         owner <= OWN_NONE;
      else
         owner <= next_owner(if_gnt, lsu_gnt, lsu_we);
   end

   assign if_rvalid  = (owner == OWN_IF);
   assign lsu_rvalid = (owner == OWN_LSU);
   assign if_rdata   = if_rvalid  ? ReadData : '0;
   assign lsu_rdata  = lsu_rvalid ? ReadData : '0;

endmodule
